// File: rtl/wta_k_if.sv
// Spike-side bundle of the k-winner-take-all block: raw spike lines and k request in,
// winner pulses and per-gamma status out.
interface wta_k_if #(
    parameter int NUM_INPUTS = 16
) ();
    localparam int KW = $clog2(NUM_INPUTS + 1);

    logic [NUM_INPUTS-1:0] input_spikes;
    logic [KW-1:0]         k_cfg;
    logic [NUM_INPUTS-1:0] output_spikes;
    logic [KW-1:0]         win_count;
    logic                  gamma_start;
    logic                  inhibited;

    modport master (
        output input_spikes, k_cfg,
        input  output_spikes, win_count, gamma_start, inhibited
    );

    modport slave (
        input  input_spikes, k_cfg,
        output output_spikes, win_count, gamma_start, inhibited
    );
endinterface

// File: rtl/wta_k.sv
// k-winner-take-all for a temporal-coded spiking column: the first k distinct lines to
// spike in each gamma cycle win and each winner emits one fixed-width output pulse.
module wta_k #(
    parameter int GAMMA_CYCLE_WIDTH = 16,
    parameter int PULSE_WIDTH       = 8,
    parameter int NUM_INPUTS        = 16,
    parameter int K                 = 1,
    parameter int TIE_MODE          = 0
) (
    input logic    aclk,
    input logic    rst,
    wta_k_if.slave bus
);
    localparam int KW = $clog2(NUM_INPUTS + 1);
    localparam int GW = (GAMMA_CYCLE_WIDTH > 1) ? $clog2(GAMMA_CYCLE_WIDTH) : 1;
    localparam int PW = $clog2(PULSE_WIDTH + 1);

    localparam logic [GW-1:0] GAMMA_LAST = GW'(GAMMA_CYCLE_WIDTH - 1);
    localparam logic [KW-1:0] K_MAX      = KW'(NUM_INPUTS);
    localparam logic [KW-1:0] K_RST      = KW'(K);
    localparam logic [PW-1:0] PULSE_LOAD = PW'(PULSE_WIDTH);

    logic [GW-1:0]         gamma_q, gamma_d;
    logic [KW-1:0]         k_active_q, k_active_d;
    logic [KW-1:0]         win_count_q, win_count_d;
    logic [NUM_INPUTS-1:0] prev_q;
    logic [NUM_INPUTS-1:0] fired_q, fired_d;
    logic [NUM_INPUTS-1:0] out_q, out_d;
    logic [PW-1:0]         pulse_q [NUM_INPUTS];
    logic [PW-1:0]         pulse_d [NUM_INPUTS];

    logic                  boundary;
    logic [NUM_INPUTS-1:0] event_w;
    logic [NUM_INPUTS-1:0] win_w;
    logic [KW-1:0]         remaining;
    logic [KW-1:0]         nwin;
    logic [KW:0]           win_sum;

    assign boundary  = (gamma_q == GAMMA_LAST);
    assign gamma_d   = boundary ? '0 : gamma_q + GW'(1);
    assign event_w   = bus.input_spikes & ~prev_q & ~fired_q;
    assign remaining = (win_count_q >= k_active_q) ? '0 : k_active_q - win_count_q;

    // Lowest index first; in tie mode 1 every event wins as long as any slot is left.
    always_comb begin
        win_w = '0;
        nwin  = '0;
        for (int i = 0; i < NUM_INPUTS; i++) begin
            if (event_w[i] && (remaining != '0) && ((TIE_MODE != 0) || (nwin < remaining))) begin
                win_w[i] = 1'b1;
                nwin     = nwin + KW'(1);
            end
        end
    end

    assign win_sum = {1'b0, win_count_q} + {1'b0, nwin};

    // The boundary clear overrides any winner update landing on the same edge.
    always_comb begin
        fired_d     = fired_q | win_w;
        win_count_d = (win_sum > {1'b0, K_MAX}) ? K_MAX : win_sum[KW-1:0];
        k_active_d  = k_active_q;
        for (int i = 0; i < NUM_INPUTS; i++) begin
            if (win_w[i]) begin
                pulse_d[i] = PULSE_LOAD;
            end else if (pulse_q[i] != '0) begin
                pulse_d[i] = pulse_q[i] - PW'(1);
            end else begin
                pulse_d[i] = '0;
            end
        end
        if (boundary) begin
            fired_d     = '0;
            win_count_d = '0;
            k_active_d  = (bus.k_cfg > K_MAX) ? K_MAX : bus.k_cfg;
            for (int i = 0; i < NUM_INPUTS; i++) begin
                pulse_d[i] = '0;
            end
        end
        for (int i = 0; i < NUM_INPUTS; i++) begin
            out_d[i] = (pulse_d[i] != '0);
        end
    end

    always_ff @(posedge aclk or negedge rst) begin
        if (!rst) begin
            gamma_q     <= '0;
            k_active_q  <= K_RST;
            win_count_q <= '0;
            prev_q      <= '0;
            fired_q     <= '0;
            out_q       <= '0;
            for (int i = 0; i < NUM_INPUTS; i++) begin
                pulse_q[i] <= '0;
            end
        end else begin
            gamma_q     <= gamma_d;
            k_active_q  <= k_active_d;
            win_count_q <= win_count_d;
            prev_q      <= bus.input_spikes;
            fired_q     <= fired_d;
            out_q       <= out_d;
            for (int i = 0; i < NUM_INPUTS; i++) begin
                pulse_q[i] <= pulse_d[i];
            end
        end
    end

    assign bus.output_spikes = out_q;
    assign bus.win_count     = win_count_q;
    assign bus.gamma_start   = (gamma_q == '0);
    assign bus.inhibited     = (win_count_q >= k_active_q);

endmodule

// File: tb/tb_wta_k.sv
// Directed bench for wta_k: two instances (lowest-index and all-tied tie modes) share
// clock, reset and stimulus; expectations are hand-computed per gamma count.
module tb_wta_k;
    localparam int N  = 16;
    localparam int GW = 16;
    localparam int PW = 8;

    logic        aclk = 1'b0;
    logic        rst  = 1'b0;
    logic [15:0] spikes = '0;
    logic [4:0]  kcfg   = 5'd1;

    int n_tests = 0;
    int n_fail  = 0;

    wta_k_if #(.NUM_INPUTS(N)) ifa ();
    wta_k_if #(.NUM_INPUTS(N)) ifb ();

    assign ifa.input_spikes = spikes;
    assign ifa.k_cfg        = kcfg;
    assign ifb.input_spikes = spikes;
    assign ifb.k_cfg        = kcfg;

    wta_k #(.GAMMA_CYCLE_WIDTH(GW), .PULSE_WIDTH(PW), .NUM_INPUTS(N), .K(1), .TIE_MODE(0))
        dut_a (.aclk(aclk), .rst(rst), .bus(ifa));
    wta_k #(.GAMMA_CYCLE_WIDTH(GW), .PULSE_WIDTH(PW), .NUM_INPUTS(N), .K(1), .TIE_MODE(1))
        dut_b (.aclk(aclk), .rst(rst), .bus(ifb));

    always #5 aclk = ~aclk;

    typedef struct {
        string       name;
        logic [4:0]  k;
        logic [15:0] rise_a;
        int          c_a;
        logic [15:0] rise_b;
        int          c_b;
        logic [15:0] exp_a;
        logic [15:0] exp_b;
        int          wc_a;
        int          wc_b;
    } vec_t;

    vec_t vecs[5];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge aclk);
        #1;
    endtask

    task automatic wait_g0();
        int n;
        n = 0;
        while (ifa.gamma_start !== 1'b1 && n < 40) begin
            step();
            n++;
        end
        chk("gamma_start_timeout", {31'd0, ifa.gamma_start}, 32'd1);
    endtask

    task automatic run_vec(input vec_t v);
        int          ksat;
        int          first;
        int          last;
        int          wa;
        int          wb;
        logic [15:0] ea;
        logic [15:0] eb;
        kcfg   = v.k;
        spikes = '0;
        step();
        wait_g0();
        ksat  = (v.k > 5'd16) ? 16 : int'(v.k);
        first = v.c_a + 1;
        last  = (v.c_a + PW > GW - 1) ? GW - 1 : v.c_a + PW;
        for (int c = 0; c < GW; c++) begin
            wa = (c > v.c_a) ? v.wc_a : 0;
            wb = (c > v.c_a) ? v.wc_b : 0;
            ea = (c >= first && c <= last) ? v.exp_a : 16'h0;
            eb = (c >= first && c <= last) ? v.exp_b : 16'h0;
            chk($sformatf("%s out_a c%0d", v.name, c), ifa.output_spikes, ea);
            chk($sformatf("%s out_b c%0d", v.name, c), ifb.output_spikes, eb);
            chk($sformatf("%s wc_a c%0d", v.name, c), ifa.win_count, wa);
            chk($sformatf("%s wc_b c%0d", v.name, c), ifb.win_count, wb);
            chk($sformatf("%s inh_a c%0d", v.name, c), ifa.inhibited, (wa >= ksat) ? 1 : 0);
            chk($sformatf("%s inh_b c%0d", v.name, c), ifb.inhibited, (wb >= ksat) ? 1 : 0);
            spikes = ((c >= v.c_a) ? v.rise_a : 16'h0) | ((c >= v.c_b) ? v.rise_b : 16'h0);
            step();
        end
        chk($sformatf("%s wrap out_a", v.name), ifa.output_spikes, 16'h0);
        chk($sformatf("%s wrap wc_a", v.name), ifa.win_count, 0);
        chk($sformatf("%s wrap gs", v.name), ifa.gamma_start, 1);
    endtask

    initial begin
        vecs[0] = '{"default_k1", 5'd1, 16'h0020, 3, 16'h0200, 6, 16'h0020, 16'h0020, 1, 1};
        vecs[1] = '{"k2_tie", 5'd2, 16'h1088, 2, 16'h0000, 99, 16'h0088, 16'h1088, 2, 3};
        vecs[2] = '{"truncate", 5'd1, 16'h0001, 12, 16'h0000, 99, 16'h0001, 16'h0001, 1, 1};
        vecs[3] = '{"k0", 5'd0, 16'h0010, 1, 16'h0400, 5, 16'h0000, 16'h0000, 0, 0};
        vecs[4] = '{"ksat", 5'd20, 16'hFFFF, 1, 16'h0000, 99, 16'hFFFF, 16'hFFFF, 16, 16};

        // Reset sequence
        rst = 1'b0;
        repeat (3) @(posedge aclk);
        #1;
        chk("rst out_a", ifa.output_spikes, 16'h0);
        chk("rst wc_a", ifa.win_count, 0);
        chk("rst gs_a", ifa.gamma_start, 1);
        chk("rst inh_a", ifa.inhibited, 0);
        chk("rst out_b", ifb.output_spikes, 16'h0);
        rst = 1'b1;
        chk("rel gs", ifa.gamma_start, 1);
        step();
        chk("rel gs c1", ifa.gamma_start, 0);
        repeat (15) step();
        chk("rel gs c16", ifa.gamma_start, 1);

        for (int i = 0; i < 5; i++) begin
            run_vec(vecs[i]);
        end

        // Runtime k: a mid-cycle k_cfg change must wait for the boundary
        kcfg   = 5'd1;
        spikes = '0;
        step();
        wait_g0();
        step();
        spikes = 16'h0400;
        step();
        chk("rtk line10 c2", ifa.output_spikes, 16'h0400);
        repeat (6) step();
        kcfg = 5'd3;
        step();
        spikes = 16'h0C00;
        step();
        chk("rtk blocked out_a", ifa.output_spikes, 16'h0000);
        chk("rtk blocked wc_a", ifa.win_count, 1);
        chk("rtk blocked wc_b", ifb.win_count, 1);
        chk("rtk blocked inh", ifa.inhibited, 1);
        spikes = '0;
        wait_g0();
        chk("rtk new inh", ifa.inhibited, 0);
        step();
        spikes = 16'h0002;
        step();
        spikes = 16'h0006;
        step();
        spikes = 16'h0016;
        step();
        spikes = 16'h0116;
        step();
        chk("rtk c5 out_a", ifa.output_spikes, 16'h0016);
        chk("rtk c5 out_b", ifb.output_spikes, 16'h0016);
        chk("rtk c5 wc", ifa.win_count, 3);
        chk("rtk c5 inh", ifa.inhibited, 1);
        repeat (5) step();
        chk("rtk c10 out", ifa.output_spikes, 16'h0014);
        step();
        chk("rtk c11 out", ifa.output_spikes, 16'h0010);
        step();
        chk("rtk c12 out", ifa.output_spikes, 16'h0000);

        // Mid-pulse reset with the winning line held high through release
        kcfg   = 5'd1;
        spikes = '0;
        step();
        wait_g0();
        step();
        spikes = 16'h0040;
        step();
        chk("mpr c2 out", ifa.output_spikes, 16'h0040);
        repeat (3) step();
        chk("mpr c5 out", ifa.output_spikes, 16'h0040);
        rst = 1'b0;
        #1;
        chk("mpr async out_a", ifa.output_spikes, 16'h0);
        chk("mpr async out_b", ifb.output_spikes, 16'h0);
        chk("mpr async wc", ifa.win_count, 0);
        chk("mpr async gs", ifa.gamma_start, 1);
        chk("mpr async inh", ifa.inhibited, 0);
        repeat (2) @(posedge aclk);
        #1;
        rst = 1'b1;
        chk("mpr rel gs", ifa.gamma_start, 1);
        chk("mpr rel out", ifa.output_spikes, 16'h0);
        step();
        chk("mpr rewin out_a", ifa.output_spikes, 16'h0040);
        chk("mpr rewin out_b", ifb.output_spikes, 16'h0040);
        chk("mpr rewin wc", ifa.win_count, 1);
        chk("mpr rewin inh", ifa.inhibited, 1);
        chk("mpr rewin gs", ifa.gamma_start, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/wta_k.md
Name: wta_k

Overview:
- Parametrised k-winner-take-all (k-WTA) for the temporal-coded spiking column; generalises the single-winner WTA.
- Tracks gamma cycles internally. Each gamma cycle, the first k distinct input lines to spike win, and each winner emits one fixed-width output pulse.
- k is runtime-configurable and latched per gamma cycle. The tie-break policy is selectable.
- Sits between the neuron/synapse array's spike outputs and the downstream STDP/readout logic.

Parameters:
- GAMMA_CYCLE_WIDTH, 16, clock cycles per gamma cycle (≥2).
- PULSE_WIDTH, 8, output pulse length in cycles (1 ≤ PULSE_WIDTH < GAMMA_CYCLE_WIDTH).
- NUM_INPUTS, 16, number of spike lines.
- K, 1, reset value of the active k (0..NUM_INPUTS).
- TIE_MODE, 0, tie handling when simultaneous events exceed remaining slots:
  - 0 = lowest index wins;
  - 1 = all tied events win.

Ports:
- aclk  input  1  clock.
- rst  input  1  asynchronous reset, active-low (0 = reset).
- input_spikes  input  NUM_INPUTS  raw spike lines, level.
- k_cfg  input  $clog2(NUM_INPUTS+1)  requested k; sampled at the gamma boundary.
- output_spikes  output  NUM_INPUTS  winner pulses, registered.
- win_count  output  $clog2(NUM_INPUTS+1)  winners so far this gamma cycle.
- gamma_start  output  1  high while gamma counter == 0.
- inhibited  output  1  high when win_count ≥ k_active.

Behaviour:
- Reset (rst=0), asynchronous; all of the following apply immediately:
  - gamma_cnt=0; k_active=K; prev=0; fired=0; pulse counters=0; win_count=0;
  - output_spikes=0; gamma_start=1; inhibited=(K==0).
- Gamma counter: counts 0..GAMMA_CYCLE_WIDTH-1, then wraps to 0.
  - On the edge entering count 0 (the boundary edge): fired, win_count and all pulse counters clear, and k_active ← k_cfg.
  - k_cfg values > NUM_INPUTS saturate to NUM_INPUTS.
- Event detection: event[i] = input_spikes[i] & ~prev[i] & ~fired[i].
  - prev is registered every cycle, including boundary cycles.
  - A line held high across reset release counts as an event in the first cycle (prev resets to 0).
  - A line held high across a boundary does not re-trigger.
- Selection: remaining = k_active − win_count (0 if negative).
  - If popcount(event) ≤ remaining, all events win.
  - Otherwise, TIE_MODE 0: the lowest-index `remaining` events win.
  - Otherwise, TIE_MODE 1: all events win, and win_count may exceed k_active.
  - Losing events set nothing: a loser that later re-rises in the same gamma cycle is still blocked by inhibition.
- Winner update, on the next edge after the event:
  - fired[i]←1;
  - win_count += number of winners (saturates at NUM_INPUTS);
  - pulse counter[i] ← PULSE_WIDTH.
- Output timing:
  - output_spikes[i] = (pulse counter[i] ≠ 0); each counter decrements once per cycle.
  - An event at count c gives output high during counts c+1 .. min(c+PULSE_WIDTH, GAMMA_CYCLE_WIDTH-1).
  - Pulses are truncated by the boundary clear, so output is always 0 at count 0.
- Events in the count-0 cycle belong to the new gamma cycle and use the new k_active.
- Each line wins at most once per gamma cycle.
- inhibited is combinational from registers. k_active=0 gives inhibited=1 and no winners for the whole gamma cycle.
- Reset mid-pulse: output drops to 0 asynchronously. The gamma cycle restarts at count 0 on release.

Test Plan:
- Reset sequence: rst=0 for 3 cycles, then release with inputs 0 → output_spikes=0x0000, win_count=0, gamma_start=1 on the first cycle, and gamma_start=1 again 16 cycles later.
- Defaults, k_cfg=1:
  - Stimulus: line 5 rises at count 3, then line 9 rises at count 6.
  - Required: output_spikes=0x0020 for counts 4..11; win_count=1 and inhibited=1 from count 4; line 9 never appears.
- K=2, TIE_MODE=0:
  - Stimulus: lines 3, 7, 12 rise together at count 2.
  - Required: output_spikes=0x0088 for counts 3..10; win_count=2.
  - Same stimulus with TIE_MODE=1: output_spikes=0x1088, win_count=3.
- Truncation: line 0 rises at count 12 → output high at counts 13,14,15, low at count 0 of the next gamma cycle; win_count=0 at count 0.
- Runtime k:
  - Stimulus: drive k_cfg=3 mid-cycle, then lines 1, 2, 4, 8 rise singly at counts 1, 2, 3, 4 of the next gamma cycle.
  - Required: the change takes effect only at the next boundary; in that cycle lines 1, 2, 4 win (0x0016) and line 8 is blocked. k_cfg=0 → no output for the whole gamma cycle.
- Mid-pulse reset, held input: line 6 wins, rst=0 at count 5 → output_spikes=0 immediately. Line 6 held high through release → re-wins at count 0 after reset (output 0x0040 at count 1).
